// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-write FIFO between the MEM stage and the data memory port.
//            Loads bypass queued stores unless they hit the same word.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_mask,
    input  logic        req_sext,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err,
    output logic        empty,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    output logic [1:0]  mem_maskMode,
    output logic        mem_sext,
    input  logic        mem_good,
    input  logic [31:0] mem_readData
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_CNT_W-1:0] r_count_q,  w_count_d;
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [DEPTH-1:0]   r_valid_q,  w_valid_d;
    logic               r_resp_valid_q, w_resp_valid_d;
    logic [31:0]        r_resp_rdata_q, w_resp_rdata_d;
    logic               r_err_q,        w_err_d;

    logic [31:0] r_addr_q [DEPTH];
    logic [31:0] r_data_q [DEPTH];
    logic [1:0]  r_mask_q [DEPTH];

    logic             w_illegal;
    logic             w_full;
    logic             w_bad;
    logic             w_store;
    logic             w_load_issue;
    logic             w_drain;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hit;
    logic             w_hazard;

    always_comb begin
        w_illegal = (req_read & req_write)
                  | (req_mask == 2'b11)
                  | ((req_mask == 2'b01) & req_addr[0])
                  | ((req_mask == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    // A load must not overtake a pending store to the same word.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
        assign w_hit[i] = r_valid_q[i] & (r_addr_q[i][31:2] == req_addr[31:2]);
    end
    assign w_hazard = |w_hit;

    // When full, loads are held off so the drain always makes progress.
    assign w_full       = (r_count_q == c_FULL);
    assign w_bad        = req_valid & w_illegal;
    assign w_store      = req_valid & ~w_illegal & req_write;
    assign w_load_issue = req_valid & ~w_illegal & req_read & ~w_hazard & ~w_full;
    assign w_drain      = ~w_load_issue & (r_count_q != '0);
    assign w_push       = w_store & ~w_full;
    assign w_pop        = w_drain & mem_good;

    assign req_ready  = w_bad | w_push | (w_load_issue & mem_good);
    assign empty      = (r_count_q == '0);
    assign resp_valid = r_resp_valid_q;
    assign resp_rdata = r_resp_rdata_q;
    assign err        = r_err_q;

    always_comb begin
        mem_valid     = 1'b0;
        mem_addr      = '0;
        mem_writeData = '0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        mem_maskMode  = 2'b00;
        mem_sext      = 1'b0;
        if (w_load_issue) begin
            mem_valid    = 1'b1;
            mem_memRead  = 1'b1;
            mem_addr     = req_addr;
            mem_maskMode = req_mask;
            mem_sext     = req_sext;
        end else if (w_drain) begin
            mem_valid     = 1'b1;
            mem_memWrite  = 1'b1;
            mem_addr      = r_addr_q[r_rd_ptr_q];
            mem_writeData = r_data_q[r_rd_ptr_q];
            mem_maskMode  = r_mask_q[r_rd_ptr_q];
        end
    end

    always_comb begin
        w_count_d  = r_count_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_valid_d  = r_valid_q;
        if (w_push) begin
            w_wr_ptr_d            = r_wr_ptr_q + c_PTR_W'(1);
            w_valid_d[r_wr_ptr_q] = 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d            = r_rd_ptr_q + c_PTR_W'(1);
            w_valid_d[r_rd_ptr_q] = 1'b0;
        end
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_d = r_count_q - c_CNT_W'(1);
        end
        w_resp_valid_d = w_load_issue & mem_good;
        w_resp_rdata_d = w_resp_valid_d ? mem_readData : r_resp_rdata_q;
        w_err_d        = w_bad;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count_q      <= '0;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_valid_q      <= '0;
            r_resp_valid_q <= 1'b0;
            r_resp_rdata_q <= '0;
            r_err_q        <= 1'b0;
        end else begin
            r_count_q      <= w_count_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_valid_q      <= w_valid_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_rdata_q <= w_resp_rdata_d;
            r_err_q        <= w_err_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr_q] <= req_addr;
            r_data_q[r_wr_ptr_q] <= req_wdata;
            r_mask_q[r_wr_ptr_q] <= req_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Self-checking bench for store_buffer against a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_mask;
    logic        req_sext;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        empty;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [1:0]  mem_maskMode;
    logic        mem_sext;
    logic        mem_good;
    logic [31:0] mem_readData;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_read(req_read), .req_write(req_write),
        .req_mask(req_mask), .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .err(err), .empty(empty),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_writeData(mem_writeData),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_maskMode(mem_maskMode), .mem_sext(mem_sext),
        .mem_good(mem_good), .mem_readData(mem_readData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  mask;
    } st_t;

    st_t         q[$];
    logic [7:0]  mem [256];
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        s_ready;
    logic        s_mem_valid;
    logic        s_mem_write;
    logic [31:0] s_mem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] ld_fn(input logic [31:0] a, input logic [1:0] m, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[a[7:0]];
        h = {mem[8'(a[7:0] + 8'd1)], mem[a[7:0]]};
        case (m)
            2'b00:   return sx ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   return sx ? {{16{h[15]}}, h} : {16'd0, h};
            default: return {mem[8'(a[7:0] + 8'd3)], mem[8'(a[7:0] + 8'd2)], h};
        endcase
    endfunction

    task automatic mem_write(input st_t e);
        for (int k = 0; k < 4; k++) begin
            if (k == 0 || (k == 1 && e.mask != 2'b00) || (k >= 2 && e.mask == 2'b10))
                mem[8'(e.addr[7:0] + 8'(k))] = e.data[8*k +: 8];
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr, input logic [1:0] m,
                        input logic sx, input logic g, input logic rst_n);
        logic ill, full, haz, ldi, drn, rdy;
        logic [31:0] rdata;
        st_t e;
        req_valid = v; req_addr = a; req_wdata = d; req_read = rd; req_write = wr;
        req_mask = m; req_sext = sx; mem_good = g; reset = rst_n;
        rdata = ld_fn(a, m, sx);
        mem_readData = rdata;
        #1;
        ill  = v && ((rd && wr) || m == 2'b11 || (m == 2'b01 && a[0]) ||
                     (m == 2'b10 && a[1:0] != 2'b00));
        full = (q.size() == DEPTH);
        haz  = 1'b0;
        foreach (q[i]) if (q[i].addr[31:2] == a[31:2]) haz = 1'b1;
        ldi  = v && !ill && rd && !haz && !full;
        drn  = !ldi && q.size() > 0;
        rdy  = v && (ill || (wr && !full) || (ldi && g));
        if (rst_n) begin
            check("req_ready", req_ready, rdy);
            check("mem_valid", mem_valid, ldi || drn);
            check("mem_memRead", mem_memRead, ldi);
            check("mem_memWrite", mem_memWrite, drn);
            check("empty", empty, q.size() == 0);
            if (drn) begin
                check("drain_addr", mem_addr, q[0].addr);
                check("drain_data", mem_writeData, q[0].data);
                check("drain_mask", mem_maskMode, q[0].mask);
                check("drain_sext", mem_sext, 1'b0);
            end
            if (ldi) begin
                check("load_addr", mem_addr, a);
                check("load_mask", mem_maskMode, m);
                check("load_sext", mem_sext, sx);
            end
        end
        s_ready = req_ready; s_mem_valid = mem_valid;
        s_mem_write = mem_memWrite; s_mem_addr = mem_addr;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_rv = 1'b0; exp_err = 1'b0; exp_rd = '0;
        end else begin
            if (drn && g) begin
                mem_write(q[0]);
                void'(q.pop_front());
            end
            if (v && !ill && wr && !full) begin
                e.addr = a; e.data = d; e.mask = m;
                q.push_back(e);
            end
            exp_err = ill;
            exp_rv  = ldi && g;
            if (exp_rv) exp_rd = rdata;
        end
        #1;
        check("resp_valid", resp_valid, exp_rv);
        check("err", err, exp_err);
        check("empty_post", empty, q.size() == 0);
        if (exp_rv) check("resp_rdata", resp_rdata, exp_rd);
    endtask

    task automatic idle(input logic g);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, g, 1'b1);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic g);
        step(1'b1, a, d, 1'b0, 1'b1, 2'b10, 1'b0, g, 1'b1);
    endtask

    initial begin
        int waited;
        logic v, rd, wr, sx, g, rst_n;
        logic [1:0]  m;
        logic [31:0] a;
        int kind;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        req_valid = 0; req_addr = 0; req_wdata = 0; req_read = 0; req_write = 0;
        req_mask = 0; req_sext = 0; mem_good = 0; mem_readData = 0; reset = 0;
        exp_rv = 0; exp_err = 0; exp_rd = 0;
        @(posedge clk); #1;

        // Reset state
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_err", err, 1'b0);

        // Fill to DEPTH, then a 5th store is refused while the head pops
        for (int i = 0; i < 4; i++) sw(32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
        sw(32'h10, 32'hDEAD_BEEF, 1'b1);
        check("full_store_ready", s_ready, 1'b0);
        check("pop0_addr", s_mem_addr, 32'h00);
        for (int i = 1; i < 4; i++) begin
            idle(1'b1);
            check("pop_write", s_mem_write, 1'b1);
            check("pop_addr", s_mem_addr, 32'(i * 4));
        end
        check("drained_empty", empty, 1'b1);

        // Load behind a store to the same word waits for the drain
        sw(32'h10, 32'h1122_3344, 1'b0);
        step(1'b1, 32'h10, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        check("hazard_stall", s_ready, 1'b0);
        waited = 0;
        while (!s_ready && waited < 10) begin
            step(1'b1, 32'h10, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
            waited++;
        end
        check("hazard_timeout", s_ready, 1'b1);
        check("lw_after_sw", resp_rdata, 32'h1122_3344);
        check("lw_resp_valid", resp_valid, 1'b1);

        // Signed byte load from the top byte of 0x80AABBCC
        sw(32'h20, 32'h80AA_BBCC, 1'b1);
        idle(1'b1);
        step(1'b1, 32'h23, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        check("lb_ready", s_ready, 1'b1);
        check("lb_resp_valid", resp_valid, 1'b1);
        check("lb_sext", resp_rdata, 32'hFFFF_FF80);

        // Illegal requests
        step(1'b1, 32'h01, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1);
        check("ill_lh_memvalid", s_mem_valid, 1'b0);
        check("ill_lh_err", err, 1'b1);
        check("ill_lh_empty", empty, 1'b1);
        step(1'b1, 32'h04, 32'd0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        check("ill_rw_memvalid", s_mem_valid, 1'b0);
        check("ill_rw_err", err, 1'b1);

        // Memory back-pressure holds the head
        sw(32'h30, 32'h0000_3030, 1'b0);
        sw(32'h34, 32'h0000_3434, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check("hold_addr", s_mem_addr, 32'h30);
            check("hold_count", q.size(), 32'd2);
        end
        idle(1'b1);
        check("release_addr", s_mem_addr, 32'h30);
        idle(1'b1);
        check("release2_addr", s_mem_addr, 32'h34);
        check("release_empty", empty, 1'b1);

        // Reset while three stores are pending
        for (int i = 0; i < 3; i++) sw(32'h50 + 32'(i * 4), 32'h5555_0000 + 32'(i), 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check("midrst_empty", empty, 1'b1);
        check("midrst_resp_valid", resp_valid, 1'b0);
        idle(1'b1);
        check("midrst_no_write", s_mem_valid, 1'b0);

        // Randomized traffic over a small set of words to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            v     = ($urandom_range(0, 9) < 8);
            g     = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            sx    = 1'($urandom);
            kind  = $urandom_range(0, 19);
            a     = 32'h40 + 32'($urandom_range(0, 7) * 4);
            m     = 2'($urandom_range(0, 2));
            rd    = ($urandom_range(0, 1) == 0);
            wr    = !rd;
            case (m)
                2'b00: a = a + 32'($urandom_range(0, 3));
                2'b01: a = a + 32'($urandom_range(0, 1) * 2);
                default: ;
            endcase
            if (kind == 0) begin rd = 1'b1; wr = 1'b1; end
            else if (kind == 1) m = 2'b11;
            else if (kind == 2) begin m = 2'b01; a = a | 32'd1; end
            else if (kind == 3) begin m = 2'b10; a = a | 32'd2; end
            step(v, a, $urandom, rd, wr, m, sx, g, rst_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
